var_timer: RTL and testbench



---
 rtl/var_timer.sv | 26 ++
 tb/tb_var_timer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/var_timer.sv
// var_timer: programmable period timer emitting a one-cycle registered tick every period clk cycles.
module var_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] period,
    output logic             clkOut
);
    logic [WIDTH-1:0] i;
    logic             w_term;
    // period 0 means 2^WIDTH, so wrap only at all-ones; otherwise >= also catches shrunk periods
    always_comb w_term = (period == '0) ? (i == '1) : (i >= period - WIDTH'(1));
    always_ff @(posedge clk) begin
        if (reset) begin
            i      <= '0;
            clkOut <= 1'b0;
        end else if (!enable) begin
            clkOut <= 1'b0;
        end else begin
            i      <= w_term ? '0 : i + WIDTH'(1);
            clkOut <= w_term;
        end
    end
endmodule

// File: tb/tb_var_timer.sv
// tb_var_timer: table-driven directed checks of var_timer at WIDTH=3.
module tb_var_timer;
    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] per;
        logic [2:0] exp_i;
        logic       exp_clk;
        string      name;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] period = 3'd5;
    logic       clk_out;
    int         checks = 0;
    int         errors = 0;
    vec_t       tbl[$];

    var_timer #(.WIDTH(3)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .period(period),
        .clkOut(clk_out)
    );

    always #5 clk = ~clk;

    function automatic void add(logic r, logic e, logic [2:0] p, logic [2:0] ei, logic ec, string n);
        vec_t v;
        v.rst = r; v.en = e; v.per = p; v.exp_i = ei; v.exp_clk = ec; v.name = n;
        tbl.push_back(v);
    endfunction

    task automatic check(string n, logic [2:0] ei, logic ec);
        checks++;
        if (dut.i !== ei || clk_out !== ec) begin
            errors++;
            $display("FAIL %s: got i=%0d clkOut=%b, want i=%0d clkOut=%b", n, dut.i, clk_out, ei, ec);
        end
    endtask

    task automatic step(logic r, logic e, logic [2:0] p);
        reset = r; enable = e; period = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        // period 5 from reset: pulses after edges 5 and 10
        add(1, 1, 5, 0, 0, "reset");
        for (int k = 1; k <= 12; k++)
            add(0, 1, 5, 3'(k % 5), (k % 5) == 0, "p5_run");
        // period 0 encodes 8
        add(1, 1, 0, 0, 0, "reset_p0");
        for (int k = 1; k <= 16; k++)
            add(0, 1, 0, 3'(k % 8), (k % 8) == 0, "p0_run");
        // period 1: continuous pulse train
        add(1, 1, 1, 0, 0, "reset_p1");
        for (int k = 0; k < 3; k++)
            add(0, 1, 1, 0, 1, "p1_run");
        // shrink period 7 -> 3 while i=5
        add(1, 1, 7, 0, 0, "reset_p7");
        for (int k = 1; k <= 5; k++)
            add(0, 1, 7, 3'(k), 0, "p7_run");
        add(0, 1, 3, 0, 1, "shrink_wrap");
        add(0, 1, 3, 1, 0, "p3_run");
        add(0, 1, 3, 2, 0, "p3_run");
        add(0, 1, 3, 0, 1, "p3_pulse");
        // pause at i=2
        add(1, 1, 5, 0, 0, "reset_pause");
        add(0, 1, 5, 1, 0, "pre_pause");
        add(0, 1, 5, 2, 0, "pre_pause");
        for (int k = 0; k < 3; k++)
            add(0, 0, 5, 2, 0, "paused");
        add(0, 1, 5, 3, 0, "resume");
        add(0, 1, 5, 4, 0, "resume");
        add(0, 1, 5, 0, 1, "resume_pulse");
        // enable drops on the would-be pulse edge
        add(0, 1, 5, 1, 0, "pre_drop");
        add(0, 1, 5, 2, 0, "pre_drop");
        add(0, 1, 5, 3, 0, "pre_drop");
        add(0, 1, 5, 4, 0, "pre_drop");
        add(0, 0, 5, 4, 0, "drop_on_term");
        add(0, 1, 5, 0, 1, "late_pulse");
        // reset on the terminal edge wins
        add(1, 1, 5, 0, 0, "reset_term");
        for (int k = 1; k <= 4; k++)
            add(0, 1, 5, 3'(k), 0, "pre_reset");
        add(1, 1, 5, 0, 0, "reset_at_i4");
        for (int k = 1; k <= 5; k++)
            add(0, 1, 5, 3'(k % 5), k == 5, "after_reset");

        foreach (tbl[n]) begin
            step(tbl[n].rst, tbl[n].en, tbl[n].per);
            check(tbl[n].name, tbl[n].exp_i, tbl[n].exp_clk);
        end

        // period 6 first pulse must take exactly 6 edges, bounded wait
        step(1, 1, 6);
        cnt = 0;
        reset = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!clk_out && cnt < 20);
        checks++;
        if (cnt != 6) begin
            errors++;
            $display("FAIL p6_latency: got %0d edges, want 6", cnt);
        end
        // next edge after a pulse must be low and i=1
        step(0, 1, 6);
        check("p6_after", 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
